// File: rtl/bitserial_sub4.sv
// bitserial_sub4: bit-serial subtractor computing DIFF = (A - B) mod 2^WIDTH.
// A single full-subtractor cell and a borrow flip-flop process one bit per
// clock, LSB first. A start/done handshake frames each operation.
// Optional feature macro: BITSERIAL_SUB_OVF_EN adds the OVF output, which
// flags signed two's-complement overflow of A - B.
module bitserial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW,
  output logic             busy,
  output logic             done
`ifdef BITSERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} stateT;

  stateT            state_q;
  logic [WIDTH-1:0] aShift_q;
  logic [WIDTH-1:0] bShift_q;
  logic [WIDTH-1:0] resShift_q;
  logic [WIDTH-1:0] resShift_d;
  logic [CW-1:0]    count_q;
  logic             borrow_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrowOut_q;
  logic             busy_q;
  logic             done_q;
  logic             aBit;
  logic             bBit;
  logic             dBit;
  logic             boutBit;

`ifdef BITSERIAL_SUB_OVF_EN
  logic             aSign_q;
  logic             bSign_q;
  logic             ovf_q;
`endif

  // Full-subtractor cell on the current LSBs, and the result register's next value
  always_comb begin
    aBit       = aShift_q[0];
    bBit       = bShift_q[0];
    dBit       = aBit ^ bBit ^ borrow_q;
    boutBit    = (~aBit & bBit) | (~(aBit ^ bBit) & borrow_q);
    resShift_d = {dBit, resShift_q[WIDTH-1:1]};
  end

  // Sequencer: load operands on start, shift one bit per clock, publish on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      aShift_q    <= '0;
      bShift_q    <= '0;
      resShift_q  <= '0;
      count_q     <= '0;
      borrow_q    <= 1'b0;
      diff_q      <= '0;
      borrowOut_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef BITSERIAL_SUB_OVF_EN
      aSign_q     <= 1'b0;
      bSign_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            aShift_q   <= A;
            bShift_q   <= B;
            resShift_q <= '0;
            count_q    <= '0;
            borrow_q   <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
`ifdef BITSERIAL_SUB_OVF_EN
            aSign_q    <= A[WIDTH-1];
            bSign_q    <= B[WIDTH-1];
`endif
          end
        end
        RUN: begin
          aShift_q   <= aShift_q >> 1;
          bShift_q   <= bShift_q >> 1;
          resShift_q <= resShift_d;
          borrow_q   <= boutBit;
          count_q    <= count_q + 1'b1;
          if (count_q == LAST) begin
            diff_q      <= resShift_d;
            borrowOut_q <= boutBit;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            count_q     <= '0;
            state_q     <= IDLE;
`ifdef BITSERIAL_SUB_OVF_EN
            ovf_q       <= (aSign_q != bSign_q) & (dBit != aSign_q);
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DIFF   = diff_q;
  assign BORROW = borrowOut_q;
  assign busy   = busy_q;
  assign done   = done_q;
`ifdef BITSERIAL_SUB_OVF_EN
  assign OVF    = ovf_q;
`endif

endmodule

// File: tb/tb_bitserial_sub4.sv
// tb_bitserial_sub4: self-checking bench for bitserial_sub4.
// Expected results are pushed to a scoreboard queue when an operation is
// started and compared when the DUT pulses done.
module tb_bitserial_sub4;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
  } expT;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] DIFF;
  logic             BORROW;
  logic             busy;
  logic             done;
`ifdef BITSERIAL_SUB_OVF_EN
  logic             OVF;
`endif

  expT              expQ[$];
  int               checkCount = 0;
  int               passCount  = 0;
  int               doneCount  = 0;
  logic [WIDTH-1:0] lastDiff   = '0;

  bitserial_sub4 #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .DIFF   (DIFF),
    .BORROW (BORROW),
    .busy   (busy),
    .done   (done)
`ifdef BITSERIAL_SUB_OVF_EN
    ,
    .OVF    (OVF)
`endif
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Reference model: arithmetic on plain integers, independent of any bit loop
  function automatic expT model(input int a, input int b);
    expT e;
    int  sa, sb, sd;
    e.diff   = WIDTH'((a - b) & ((1 << WIDTH) - 1));
    e.borrow = (a < b);
    sa = (a >= (1 << (WIDTH - 1))) ? a - (1 << WIDTH) : a;
    sb = (b >= (1 << (WIDTH - 1))) ? b - (1 << WIDTH) : b;
    sd = sa - sb;
    e.ovf = (sd > (1 << (WIDTH - 1)) - 1) || (sd < -(1 << (WIDTH - 1)));
    return e;
  endfunction

  // Scoreboard: compare every done pulse against the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      expT e;
      doneCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected done", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("DIFF", 32'(DIFF), 32'(e.diff));
        checkOutput("BORROW", 32'(BORROW), 32'(e.borrow));
`ifdef BITSERIAL_SUB_OVF_EN
        checkOutput("OVF", 32'(OVF), 32'(e.ovf));
`endif
      end
      lastDiff = DIFF;
    end
  end

  // Drive a start pulse between edges and record the expected result
  task automatic applyStimulus(input int a, input int b);
    A     = WIDTH'(a);
    B     = WIDTH'(b);
    start = 1'b1;
    expQ.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    B     = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
  endtask

  // Wait (bounded) for done, counting busy cycles and checking DIFF holds meanwhile
  task automatic waitDone(output int busyCycles);
    busyCycles = 0;
    for (int k = 0; k < 4 * WIDTH; k++) begin
      @(negedge clk);
      if (done) return;
      busyCycles++;
      checkOutput("busy while running", 32'(busy), 32'd1);
      checkOutput("DIFF held while running", 32'(DIFF), 32'(lastDiff));
    end
    checkOutput("done timeout", 32'd0, 32'd1);
  endtask

  // One complete operation with latency and pulse-width checks
  task automatic runOp(input int a, input int b);
    int lat;
    applyStimulus(a, b);
    waitDone(lat);
    checkOutput("latency", 32'(lat), 32'(WIDTH));
    @(negedge clk);
    checkOutput("done pulse width", 32'(done), 32'd0);
    checkOutput("busy after done", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int doneBefore;

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset DIFF", 32'(DIFF), 32'd0);
    checkOutput("reset BORROW", 32'(BORROW), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    lastDiff = '0;

    // Directed operations, including wrap-around and overflow vectors
    runOp(9, 3);
    runOp(3, 9);
    runOp(0, 1);
    runOp(15, 15);
    runOp(7, 8);
    runOp(5, 3);

    // A start while busy must be ignored
    applyStimulus(12, 5);
    @(posedge clk);
    #1;
    A     = 4'd1;
    B     = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(lat);
    checkOutput("latency with ignored start", 32'(lat), 32'(WIDTH - 2));

    // Back-to-back: new start raised in the done cycle
    doneBefore = doneCount;
    applyStimulus(8, 2);
    @(negedge clk);
    checkOutput("b2b busy", 32'(busy), 32'd1);
    checkOutput("b2b done dropped", 32'(done), 32'd0);
    waitDone(lat);
    checkOutput("b2b latency", 32'(lat), 32'(WIDTH - 1));
    checkOutput("single done for ignored start", 32'(doneCount - doneBefore), 32'd1);
    @(negedge clk);
    checkOutput("b2b done pulse width", 32'(done), 32'd0);

    // Reset asserted during the second RUN cycle aborts the operation
    applyStimulus(10, 4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort DIFF", 32'(DIFF), 32'd0);
    checkOutput("abort BORROW", 32'(BORROW), 32'd0);
    lastDiff   = '0;
    doneBefore = doneCount;
    repeat (3 * WIDTH) @(negedge clk);
    checkOutput("no done after abort", 32'(doneCount - doneBefore), 32'd0);

    // Random operands
    for (int i = 0; i < 8; i++) begin
      runOp(int'($urandom_range(0, (1 << WIDTH) - 1)), int'($urandom_range(0, (1 << WIDTH) - 1)));
    end

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
